// File: rtl/hpu_cmd_arbiter.sv
// Per-cluster HPU command front-end: round-robin request arbitration, per-core slot
// allocation with cmd_id stamping, type-based routing and completion return to cores.
package hpu_cmd_pkg;
    localparam int unsigned HPU_NUM_CLUSTERS       = 4;
    localparam int unsigned HPU_NUM_CORES          = 8;
    localparam int unsigned HPU_NUM_HPU_CMDS       = 4;
    localparam int unsigned HPU_NUM_CMD_INTERFACES = 3;

    typedef logic [1:0] pspin_cmd_intf_id_t;

    typedef enum logic [1:0] {
        CMD_HOST_DIRECT = 2'd0,
        CMD_NIC_SEND    = 2'd1,
        CMD_HOST_MEMCPY = 2'd2,
        CMD_ILLEGAL     = 2'd3
    } pspin_cmd_type_t;

    typedef struct packed {
        logic [$clog2(HPU_NUM_CLUSTERS)-1:0] cluster_id;
        logic [$clog2(HPU_NUM_CORES)-1:0]    core_id;
        logic [$clog2(HPU_NUM_HPU_CMDS)-1:0] local_cmd_id;
    } pspin_cmd_id_t;

    typedef struct packed {
        pspin_cmd_id_t      cmd_id;
        logic               generate_event;
        pspin_cmd_type_t    cmd_type;
        pspin_cmd_intf_id_t intf_id;
        logic [31:0]        descr;
    } pspin_cmd_t;

    typedef struct packed {
        pspin_cmd_id_t cmd_id;
        logic [31:0]   data;
    } pspin_cmd_resp_t;
endpackage

module hpu_cmd_arbiter
    import hpu_cmd_pkg::*;
#(
    parameter int unsigned NUM_CORES          = HPU_NUM_CORES,
    parameter int unsigned NUM_HPU_CMDS       = HPU_NUM_HPU_CMDS,
    parameter int unsigned NUM_CMD_INTERFACES = HPU_NUM_CMD_INTERFACES
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [$clog2(HPU_NUM_CLUSTERS)-1:0]   cluster_id_i,
    input  logic [NUM_CORES-1:0]                  req_valid_i,
    output logic [NUM_CORES-1:0]                  req_ready_o,
    input  pspin_cmd_t [NUM_CORES-1:0]            req_cmd_i,
    output pspin_cmd_id_t                         req_id_o,
    output logic [NUM_CMD_INTERFACES-1:0]         cmd_valid_o,
    input  logic [NUM_CMD_INTERFACES-1:0]         cmd_ready_i,
    output pspin_cmd_t                            cmd_o,
    input  logic [NUM_CMD_INTERFACES-1:0]         resp_valid_i,
    output logic [NUM_CMD_INTERFACES-1:0]         resp_ready_o,
    input  pspin_cmd_resp_t [NUM_CMD_INTERFACES-1:0] resp_i,
    output logic [NUM_CORES-1:0]                  core_resp_valid_o,
    output pspin_cmd_resp_t                       core_resp_o,
    output logic                                  err_o
);
    localparam int unsigned CW = $clog2(NUM_CORES);
    localparam int unsigned IW = $clog2(NUM_CMD_INTERFACES);
    localparam int unsigned SW = $clog2(NUM_HPU_CMDS);

    logic [NUM_CORES-1:0][NUM_HPU_CMDS-1:0] r_busy;
    logic [CW-1:0]                          r_req_ptr;
    logic [IW-1:0]                          r_resp_ptr;
    logic [NUM_CMD_INTERFACES-1:0]          r_cmd_valid;
    pspin_cmd_t                             r_cmd;
    logic [NUM_CORES-1:0]                   r_core_resp_valid;
    pspin_cmd_resp_t                        r_core_resp;
    logic                                   r_err;

    logic                                   w_out_free;
    logic [NUM_CORES-1:0]                   w_elig;
    logic                                   w_gnt_any;
    logic [CW-1:0]                          w_gnt_idx;
    logic [SW-1:0]                          w_slot;
    logic                                   w_legal;
    pspin_cmd_t                             w_cmd_next;
    logic [NUM_CMD_INTERFACES-1:0]          w_intf_onehot;
    logic                                   w_rgnt_any;
    logic [IW-1:0]                          w_rgnt_idx;
    pspin_cmd_resp_t                        w_resp;
    logic                                   w_resp_ok;
    logic [NUM_CORES-1:0][NUM_HPU_CMDS-1:0] w_busy_next;

    always_comb begin
        w_out_free = (r_cmd_valid == '0) || ((r_cmd_valid & cmd_ready_i) != '0);
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
            w_elig[c] = req_valid_i[c] && !(&r_busy[c]) && w_out_free;
        end
    end

    // Request side: rotate from the pointer, pick the first eligible core, then its lowest free slot.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (!w_gnt_any && w_elig[CW'((32'(r_req_ptr) + i) % NUM_CORES)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = CW'((32'(r_req_ptr) + i) % NUM_CORES);
            end
        end

        w_slot = '0;
        for (int unsigned s = NUM_HPU_CMDS; s > 0; s--) begin
            if (!r_busy[w_gnt_idx][SW'(s - 1)]) w_slot = SW'(s - 1);
        end

        req_ready_o = '0;
        req_id_o    = '0;
        if (w_gnt_any) begin
            req_ready_o[w_gnt_idx] = 1'b1;
            req_id_o = '{cluster_id: cluster_id_i, core_id: w_gnt_idx, local_cmd_id: w_slot};
        end

        w_cmd_next        = req_cmd_i[w_gnt_idx];
        w_legal           = (w_cmd_next.cmd_type != CMD_ILLEGAL);
        w_cmd_next.cmd_id = req_id_o;
        case (w_cmd_next.cmd_type)
            CMD_HOST_DIRECT: w_cmd_next.intf_id = 2'd0;
            CMD_NIC_SEND:    w_cmd_next.intf_id = 2'd1;
            CMD_HOST_MEMCPY: w_cmd_next.intf_id = 2'd2;
            default:         w_cmd_next.intf_id = 2'd0;
        endcase
        w_intf_onehot = '0;
        w_intf_onehot[w_cmd_next.intf_id] = 1'b1;
    end

    // The core-side output is a one-cycle pulse, so a response can be accepted every cycle.
    always_comb begin
        w_rgnt_any = 1'b0;
        w_rgnt_idx = '0;
        for (int unsigned i = 0; i < NUM_CMD_INTERFACES; i++) begin
            if (!w_rgnt_any && resp_valid_i[IW'((32'(r_resp_ptr) + i) % NUM_CMD_INTERFACES)]) begin
                w_rgnt_any = 1'b1;
                w_rgnt_idx = IW'((32'(r_resp_ptr) + i) % NUM_CMD_INTERFACES);
            end
        end
        resp_ready_o = '0;
        if (w_rgnt_any) resp_ready_o[w_rgnt_idx] = 1'b1;

        w_resp    = resp_i[w_rgnt_idx];
        w_resp_ok = w_rgnt_any && (w_resp.cmd_id.cluster_id == cluster_id_i) &&
                    r_busy[w_resp.cmd_id.core_id][w_resp.cmd_id.local_cmd_id];

        w_busy_next = r_busy;
        if (w_gnt_any && w_legal) w_busy_next[w_gnt_idx][w_slot] = 1'b1;
        if (w_resp_ok) w_busy_next[w_resp.cmd_id.core_id][w_resp.cmd_id.local_cmd_id] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy            <= '0;
            r_req_ptr         <= '0;
            r_resp_ptr        <= '0;
            r_cmd_valid       <= '0;
            r_cmd             <= '0;
            r_core_resp_valid <= '0;
            r_core_resp       <= '0;
            r_err             <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (w_gnt_any) begin
                r_req_ptr <= (w_gnt_idx == CW'(NUM_CORES - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
            if (w_rgnt_any) begin
                r_resp_ptr <= (w_rgnt_idx == IW'(NUM_CMD_INTERFACES - 1)) ? '0 : w_rgnt_idx + 1'b1;
            end
            if (w_gnt_any && w_legal) begin
                r_cmd       <= w_cmd_next;
                r_cmd_valid <= w_intf_onehot;
            end else if ((r_cmd_valid & cmd_ready_i) != '0) begin
                r_cmd_valid <= '0;
            end
            r_core_resp_valid <= '0;
            if (w_resp_ok) begin
                r_core_resp_valid[w_resp.cmd_id.core_id] <= 1'b1;
                r_core_resp                              <= w_resp;
            end
            if ((w_gnt_any && !w_legal) || (w_rgnt_any && !w_resp_ok)) r_err <= 1'b1;
        end
    end

    assign cmd_valid_o       = r_cmd_valid;
    assign cmd_o             = r_cmd;
    assign core_resp_valid_o = r_core_resp_valid;
    assign core_resp_o       = r_core_resp;
    assign err_o             = r_err;

endmodule
